// File: rtl/s_term_uio_bridge.sv
// rtl/s_term_uio_bridge.sv - south-terminal user-IO bridge between switch matrix and user pins
module s_term_uio_bridge #(
  parameter int                NUM_CH     = 20,
  parameter logic [NUM_CH-1:0] SAFE_VALUE = {NUM_CH{1'b0}}
) (
  input  logic                  UserCLK,
  input  logic                  UserRSTn,
  input  logic [NUM_CH-1:0]     UIN,
  output logic [NUM_CH-1:0]     FOUT,
  input  logic [NUM_CH-1:0]     FIN,
  output logic [NUM_CH-1:0]     UOUT,
  input  logic [2*NUM_CH-1:0]   IN_MODE,
  input  logic [NUM_CH-1:0]     OUT_MODE,
  input  logic                  ConfigBusy,
  input  logic [NUM_CH-1:0]     EdgeClr,
  output logic [NUM_CH-1:0]     EdgeFlags
);

  logic [NUM_CH-1:0] r1;
  logic [NUM_CH-1:0] s1;
  logic [NUM_CH-1:0] s2;
  logic [NUM_CH-1:0] s3;
  logic [NUM_CH-1:0] edge_q;
  logic [NUM_CH-1:0] o_q;
  logic [NUM_CH-1:0] rise;

  // Rising edge as seen after the 2-flop synchroniser; shared by mode 11 and the sticky flags.
  assign rise = s2 & ~s3;

  // Inbound capture chain; runs in every mode so a mode change needs no warm-up.
  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      r1 <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      r1 <= UIN;
      s1 <= UIN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Sticky edge flags: a new edge beats a simultaneous clear.
  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~EdgeClr) | rise;
    end
  end

  // Outbound register loads the safe value while configuration is running.
  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      o_q <= SAFE_VALUE;
    end else begin
      o_q <= ConfigBusy ? SAFE_VALUE : FIN;
    end
  end

  // Per-channel inbound result selection.
  always_comb begin
    FOUT = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (IN_MODE[2*i +: 2])
        2'b00:   FOUT[i] = UIN[i];
        2'b01:   FOUT[i] = r1[i];
        2'b10:   FOUT[i] = s2[i];
        default: FOUT[i] = rise[i];
      endcase
    end
  end

  // Outbound selection; reset and ConfigBusy force the safe value with no delay.
  always_comb begin
    UOUT = (OUT_MODE & o_q) | (~OUT_MODE & FIN);
    if (!UserRSTn || ConfigBusy) begin
      UOUT = SAFE_VALUE;
    end
  end

  assign EdgeFlags = edge_q;

endmodule

// File: tb/tb_s_term_uio_bridge.sv
// tb/tb_s_term_uio_bridge.sv - directed table-driven bench for s_term_uio_bridge
module tb_s_term_uio_bridge;

  localparam int NUM_CH = 20;
  localparam logic [NUM_CH-1:0] SAFE = 20'h0000F;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] uin;
  logic [NUM_CH-1:0] fout;
  logic [NUM_CH-1:0] fin;
  logic [NUM_CH-1:0] uout;
  logic [2*NUM_CH-1:0] in_mode;
  logic [NUM_CH-1:0] out_mode;
  logic              busy;
  logic [NUM_CH-1:0] edge_clr;
  logic [NUM_CH-1:0] edge_flags;

  int n_cmp;
  int n_bad;

  s_term_uio_bridge #(
    .NUM_CH(NUM_CH),
    .SAFE_VALUE(SAFE)
  ) dut (
    .UserCLK(clk),
    .UserRSTn(rst_n),
    .UIN(uin),
    .FOUT(fout),
    .FIN(fin),
    .UOUT(uout),
    .IN_MODE(in_mode),
    .OUT_MODE(out_mode),
    .ConfigBusy(busy),
    .EdgeClr(edge_clr),
    .EdgeFlags(edge_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       u;
    logic [3:0] clr;
    logic [3:0] exp_fout;
    logic [3:0] exp_flags;
  } in_vec_t;

  typedef struct {
    logic              busy;
    logic [NUM_CH-1:0] fin;
    logic [NUM_CH-1:0] exp_uout;
  } out_vec_t;

  in_vec_t  in_tab[12];
  out_vec_t out_tab[10];

  task automatic check(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // ch0..3 modes 00/01/10/11, every other channel bypass
    in_tab[0]  = '{1'b1, 4'h0, 4'b0001, 4'h0};
    in_tab[1]  = '{1'b1, 4'h0, 4'b0011, 4'h0};
    in_tab[2]  = '{1'b1, 4'h0, 4'b1111, 4'h0};
    in_tab[3]  = '{1'b1, 4'h0, 4'b0111, 4'hF};
    in_tab[4]  = '{1'b0, 4'h0, 4'b0110, 4'hF};
    in_tab[5]  = '{1'b0, 4'h0, 4'b0100, 4'hF};
    in_tab[6]  = '{1'b0, 4'hF, 4'b0000, 4'hF};
    in_tab[7]  = '{1'b1, 4'h0, 4'b0001, 4'h0};
    in_tab[8]  = '{1'b0, 4'h0, 4'b0010, 4'h0};
    in_tab[9]  = '{1'b0, 4'hF, 4'b1100, 4'h0};
    in_tab[10] = '{1'b0, 4'h0, 4'b0000, 4'hF};
    in_tab[11] = '{1'b0, 4'h0, 4'b0000, 4'hF};

    // ch4..7 registered, all others bypass
    out_tab[0] = '{1'b0, 20'hFFFFF, 20'hFFFFF};
    out_tab[1] = '{1'b1, 20'hFFFFF, 20'h0000F};
    out_tab[2] = '{1'b1, 20'hFFFFF, 20'h0000F};
    out_tab[3] = '{1'b1, 20'hFFFFF, 20'h0000F};
    out_tab[4] = '{1'b0, 20'hFFFFF, 20'hFFF0F};
    out_tab[5] = '{1'b0, 20'h00000, 20'h000F0};
    out_tab[6] = '{1'b0, 20'h00000, 20'h00000};
    out_tab[7] = '{1'b0, 20'hFFFFF, 20'hFFF0F};
    out_tab[8] = '{1'b1, 20'hFFFFF, 20'h0000F};
    out_tab[9] = '{1'b0, 20'h00000, 20'h00000};

    // reset state
    rst_n    = 1'b0;
    uin      = '1;
    fin      = '1;
    busy     = 1'b0;
    edge_clr = '0;
    out_mode = '0;
    in_mode  = '0;
    in_mode[7:0] = 8'b11_10_01_00;
    step();
    step();
    check("reset_uout_bypass", uout, 20'h0000F);
    check("reset_fout", fout, 20'hFFFF1);
    check("reset_flags", edge_flags, 20'h00000);
    out_mode = '1;
    #1;
    check("reset_uout_registered", uout, 20'h0000F);
    out_mode = '0;

    // inbound latency, pulse and edge flags
    uin = '0;
    #1;
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      uin      = {16'h0, {4{in_tab[k].u}}};
      edge_clr = {16'h0, in_tab[k].clr};
      #2;
      check($sformatf("in_fout_%0d", k), fout, {16'h0, in_tab[k].exp_fout});
      check($sformatf("in_flags_%0d", k), edge_flags, {16'h0, in_tab[k].exp_flags});
      step();
    end
    edge_clr = '0;
    uin      = '0;

    // outbound hold and bypass under ConfigBusy
    out_mode = 20'h000F0;
    for (int k = 0; k < 10; k++) begin
      busy = out_tab[k].busy;
      fin  = out_tab[k].fin;
      #2;
      check($sformatf("out_uout_%0d", k), uout, out_tab[k].exp_uout);
      step();
    end
    busy = 1'b0;
    fin  = '1;

    // mid-run reset shorter than one cycle, ch2 in mode 10
    uin = '1;
    step();
    step();
    step();
    check("midrst_before", {19'h0, fout[2]}, 20'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_fout", {19'h0, fout[2]}, 20'h0);
    check("midrst_uout", uout, SAFE);
    #2;
    rst_n = 1'b1;
    step();
    check("midrst_after1", {19'h0, fout[2]}, 20'h0);
    step();
    check("midrst_after2", {19'h0, fout[2]}, 20'h1);

    // switch ch2 from mode 10 to 11 with UIN held high
    step();
    step();
    check("switch_before", {19'h0, fout[2]}, 20'h1);
    in_mode[5:4] = 2'b11;
    #1;
    check("switch_now", {19'h0, fout[2]}, 20'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("switch_nopulse_%0d", k), {19'h0, fout[2]}, 20'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/s_term_uio_bridge.md
Name: s_term_uio_bridge

Overview:
Parametrised south-terminal user-IO bridge. It sits between the terminal tile switch matrix (FIN/FOUT) and the user-project pins (UIN/UOUT), and carries NUM_CH channels in each direction. Each inbound channel is configured independently: bypass, registered, 2-flop synchronised, or synchronised rising-edge pulse. Each inbound channel also has a sticky edge flag. Outbound channels can be bypassed or registered, and are forced to a safe value while the fabric is being configured.

Parameters:
NUM_CH, 20, number of channels per direction (1..64)
SAFE_VALUE, {NUM_CH{1'b0}}, per-channel UOUT value during reset and ConfigBusy

Ports:
UserCLK  in  1  fabric user clock; all flops rise-edge
UserRSTn  in  1  asynchronous active-low reset
UIN  in  NUM_CH  user-project to fabric data
FOUT  out  NUM_CH  to switch matrix (inbound result)
FIN  in  NUM_CH  from switch matrix (outbound data)
UOUT  out  NUM_CH  to user project
IN_MODE  in  2*NUM_CH  per-channel inbound mode, bits [2i+1:2i]; static config
OUT_MODE  in  NUM_CH  per-channel outbound mode: 0 = bypass, 1 = registered
ConfigBusy  in  1  high while fabric configuration is in progress; same clock domain
EdgeClr  in  NUM_CH  per-channel clear for EdgeFlags
EdgeFlags  out  NUM_CH  sticky rising-edge flags

Behaviour:
- Reset (UserRSTn=0, asynchronous): all internal flops clear; r1, s1, s2, s3 = 0; EdgeFlags = 0; outbound register = SAFE_VALUE.
- Reset outputs: UOUT = SAFE_VALUE combinationally while reset is asserted, in every mode. FOUT = UIN in mode 00; FOUT = 0 in all other modes.
- Inbound channel i, with m = IN_MODE[2i+1:2i]; flops r1, s1, s2 and s3 always clock, independent of m:
  - r1 <= UIN[i]; s1 <= UIN[i]; s2 <= s1; s3 <= s2.
  - m=00: FOUT[i] = UIN[i], combinational, 0 cycles.
  - m=01: FOUT[i] = r1, latency 1.
  - m=10: FOUT[i] = s2, latency 2.
  - m=11: FOUT[i] = s2 & ~s3. Gives a single-cycle pulse 2 cycles after a UIN rise. Back-to-back edges on consecutive cycles are impossible; a 1-cycle UIN high produces one pulse.
- Mode change mid-operation: the new selection takes effect in the same cycle. There is no extra state, so no spurious pulse beyond what s2/s3 already encode.
- EdgeFlags[i]: set in the cycle after s2 & ~s3 = 1, in any mode. Cleared by EdgeClr[i]. If set and clear coincide, set wins: the flag stays 1.
- Outbound channel i:
  - Register o_q[i] <= ConfigBusy ? SAFE_VALUE[i] : FIN[i].
  - OUT_MODE=0: UOUT[i] = ConfigBusy ? SAFE_VALUE[i] : FIN[i], combinational.
  - OUT_MODE=1: UOUT[i] = ConfigBusy ? SAFE_VALUE[i] : o_q[i]. On ConfigBusy falling, UOUT shows SAFE_VALUE for 1 further cycle, then FIN delayed by 1.
- ConfigBusy overrides UOUT immediately (same cycle) in both modes. It does not affect inbound paths or EdgeFlags.
- Reset asserted mid-operation: every flop clears immediately and UOUT snaps to SAFE_VALUE. On release, the first UserCLK edge resumes normal capture.
- No handshakes. All paths are single-clock. UIN is treated as asynchronous only in modes 10/11.

Test Plan:
- Reset: hold UserRSTn=0, UIN=all 1, OUT_MODE=0, FIN=all 1, SAFE_VALUE=0x0000F -> UOUT=0x0000F, EdgeFlags=0, FOUT[ch with mode 00]=1, FOUT[others]=0.
- Latency per mode: ch0..3 set to modes 00/01/10/11, UIN rises at cycle 0 -> FOUT0 rises at cycle 0, FOUT1 at 1, FOUT2 at 2; FOUT3 is high only at cycle 2.
- Edge flag: mode 11, UIN 1-cycle pulse -> one FOUT pulse, EdgeFlags=1. EdgeClr asserted in the same cycle as a new set -> flag remains 1. EdgeClr alone -> flag 0 next cycle.
- Outbound hold: OUT_MODE=1, FIN=1, SAFE=0, ConfigBusy high for 3 cycles -> UOUT=0 throughout, 0 for 1 cycle after deassert, then 1. Same sequence with OUT_MODE=0 -> UOUT=1 in the same cycle as the deassert.
- Mid-run reset: mode 10 with s1=s2=1, pulse UserRSTn low for less than 1 cycle -> FOUT=0 immediately. After release with UIN=1 held -> FOUT returns to 1 2 cycles later.
- Mode switch: mode 10 with UIN held high, switch to 11 -> FOUT=0 immediately and no pulse.
